// File: rtl/rotary_pkg.sv
// Shared constants for the rotary quadrature driver: position range, Gray
// next-phase tables, FSM state encodings and the letter saturation helper.
package rotary_pkg;

    localparam int COUNT_MAX  = 104;
    localparam int POS_COUNT  = 105;
    localparam int LETTER_MAX = 26;

    localparam logic [4:0] LETTER_MAX_L = 5'd26;

    // Indexed by current AB; each 2-bit slot holds the next AB.
    localparam logic [7:0] GRAY_UP_NEXT = 8'b01_11_00_10;
    localparam logic [7:0] GRAY_DN_NEXT = 8'b10_00_11_01;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] STEP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    function automatic logic [1:0] gray_next(input logic [1:0] ab, input logic up);
        gray_next = up ? GRAY_UP_NEXT[{ab, 1'b0} +: 2] : GRAY_DN_NEXT[{ab, 1'b0} +: 2];
    endfunction

    function automatic logic [4:0] sat_letter(input logic [4:0] letter);
        sat_letter = (letter > LETTER_MAX_L) ? LETTER_MAX_L : letter;
    endfunction

endpackage

// File: rtl/quad_phase_gen.sv
// Two-bit quadrature phase register; each strobe moves AB one Gray step in
// the requested direction.
module quad_phase_gen
    import rotary_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic i_step,
    input  logic i_up,
    output logic o_a,
    output logic o_b
);

    logic [1:0] r_ab;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ab <= 2'b00;
        end else if (i_step) begin
            r_ab <= gray_next(r_ab, i_up);
        end
    end

    assign o_a = r_ab[1];
    assign o_b = r_ab[0];

endmodule

// File: rtl/rotary_quad_driver.sv
// Quadrature transmitter that walks a rotary letter decoder to a target letter
// by the shorter path. Optional abort input: define ROTARY_QUAD_ABORT_EN.
//
// state | meaning
// IDLE  | ready for a target request
// CALC  | choose direction and step count from target vs position
// STEP  | one Gray step emitted, AB held for PHASE_CYCLES, then one settle cycle after the last
// DONE  | one-cycle done pulse, back to IDLE
module rotary_quad_driver
    import rotary_pkg::*;
#(
    parameter int PHASE_CYCLES = 16,
    parameter int COUNT_MAX    = 104
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] reset_val,
`ifdef ROTARY_QUAD_ABORT_EN
    input  logic       abort,
`endif
    input  logic       target_valid,
    input  logic [4:0] target_letter,
    output logic       target_ready,
    output logic       rotary_a,
    output logic       rotary_b,
    output logic       busy,
    output logic       done,
    output logic [4:0] current_letter
);

    localparam int                HOLD_W    = $clog2(PHASE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(PHASE_CYCLES - 1);
    localparam logic [6:0]        POS_TOP   = 7'(COUNT_MAX);
    localparam logic [7:0]        POS_N     = 8'(COUNT_MAX + 1);

    logic [1:0]        r_state;
    logic [6:0]        r_pos;
    logic [6:0]        r_tgt;
    logic [6:0]        r_steps;
    logic              r_up;
    logic              r_settle;
    logic [HOLD_W-1:0] r_hold;
    logic [4:0]        r_letter;

    logic       w_abort;
    logic       w_accept;
    logic [7:0] w_fd;
    logic [7:0] w_bd;
    logic       w_calc_up;
    logic [6:0] w_calc_steps;
    logic       w_hold_end;
    logic       w_more;
    logic       w_step;
    logic       w_up;
    logic [6:0] w_pos_next;

`ifdef ROTARY_QUAD_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept = target_valid && (r_state == IDLE);

    always_comb begin
        w_fd = 8'd0;
        if (r_tgt >= r_pos) begin
            w_fd = {1'b0, r_tgt} - {1'b0, r_pos};
        end else begin
            w_fd = {1'b0, r_tgt} + POS_N - {1'b0, r_pos};
        end
    end

    // POS_N is odd, so fd and bd can never tie.
    assign w_bd         = POS_N - w_fd;
    assign w_calc_up    = (w_fd <= w_bd);
    assign w_calc_steps = w_calc_up ? 7'(w_fd) : 7'(w_bd);

    assign w_hold_end = (r_hold == '0);
    assign w_more     = (r_steps != 7'd0) && !w_abort;
    assign w_step     = ((r_state == CALC) && (w_fd != 8'd0)) ||
                        ((r_state == STEP) && w_hold_end && !r_settle && w_more);
    assign w_up       = (r_state == CALC) ? w_calc_up : r_up;

    always_comb begin
        w_pos_next = r_pos;
        if (w_up) begin
            w_pos_next = (r_pos == POS_TOP) ? 7'd0 : r_pos + 7'd1;
        end else begin
            w_pos_next = (r_pos == 7'd0) ? POS_TOP : r_pos - 7'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_pos    <= {reset_val, 2'b00};
            r_tgt    <= 7'd0;
            r_steps  <= 7'd0;
            r_up     <= 1'b0;
            r_settle <= 1'b0;
            r_hold   <= '0;
            r_letter <= reset_val;
        end else begin
            r_letter <= r_pos[6:2];

            if (w_step) begin
                r_pos  <= w_pos_next;
                r_hold <= HOLD_LOAD;
            end else if ((r_state == STEP) && !w_hold_end) begin
                r_hold <= r_hold - 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_tgt   <= {sat_letter(target_letter), 2'b00};
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_settle <= 1'b0;
                    if (w_fd == 8'd0) begin
                        r_state <= DONE;
                    end else begin
                        r_up    <= w_calc_up;
                        r_steps <= w_calc_steps - 7'd1;
                        r_state <= STEP;
                    end
                end
                STEP: begin
                    if (w_step) begin
                        r_steps <= r_steps - 7'd1;
                    end else begin
                        if (w_abort) begin
                            r_steps <= 7'd0;
                        end
                        if (w_hold_end) begin
                            if (r_settle) begin
                                r_settle <= 1'b0;
                                r_state  <= DONE;
                            end else begin
                                r_settle <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    quad_phase_gen u_phase (
        .clock (clock),
        .reset (reset),
        .i_step(w_step),
        .i_up  (w_up),
        .o_a   (rotary_a),
        .o_b   (rotary_b)
    );

    assign target_ready   = (r_state == IDLE);
    assign busy           = (r_state == CALC) || (r_state == STEP);
    assign done           = (r_state == DONE);
    assign current_letter = r_letter;

endmodule

// File: tb/tb_rotary_quad_driver.sv
// Scoreboard bench for rotary_quad_driver with a behavioural quadrature
// decoder on the AB outputs; the abort case builds with ROTARY_QUAD_ABORT_EN.
module tb_rotary_quad_driver;

    localparam int P = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] reset_val = 5'd0;
    logic       abort = 1'b0;
    logic       target_valid = 1'b0;
    logic [4:0] target_letter = 5'd0;
    logic       target_ready;
    logic       rotary_a;
    logic       rotary_b;
    logic       busy;
    logic       done;
    logic [4:0] current_letter;

    rotary_quad_driver #(.PHASE_CYCLES(P), .COUNT_MAX(104)) dut (
        .clock         (clock),
        .reset         (reset),
        .reset_val     (reset_val),
`ifdef ROTARY_QUAD_ABORT_EN
        .abort         (abort),
`endif
        .target_valid  (target_valid),
        .target_letter (target_letter),
        .target_ready  (target_ready),
        .rotary_a      (rotary_a),
        .rotary_b      (rotary_b),
        .busy          (busy),
        .done          (done),
        .current_letter(current_letter)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 = AB edge, 1 = done pulse
        int cyc;
        int val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [1:0] gray_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    int m_pos = 0;
    int m_idx = 0;
    int dec_pos = 0;
    bit mon_en = 1'b0;
    logic [1:0] prev_ab = 2'b00;

    function automatic int gray_index(input logic [1:0] ab);
        int r = 0;
        for (int i = 0; i < 4; i++) if (gray_seq[i] == ab) r = i;
        return r;
    endfunction

    always @(negedge clock) begin
        if (mon_en) begin
            if ({rotary_a, rotary_b} != prev_ab) begin
                if ({rotary_a, rotary_b} == gray_seq[(gray_index(prev_ab) + 1) % 4])
                    dec_pos = (dec_pos == 104) ? 0 : dec_pos + 1;
                else if ({rotary_a, rotary_b} == gray_seq[(gray_index(prev_ab) + 3) % 4])
                    dec_pos = (dec_pos == 0) ? 104 : dec_pos - 1;
                else
                    check("ab_illegal", {rotary_a, rotary_b}, prev_ab);
                if (sb.size() == 0) begin
                    check("ab_unexpected", {rotary_a, rotary_b}, prev_ab);
                end else begin
                    mon_e = sb.pop_front();
                    check("ab_kind", mon_e.kind, 0);
                    check("ab_cyc", cyc, mon_e.cyc);
                    check("ab_val", {rotary_a, rotary_b}, mon_e.val);
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_kind", mon_e.kind, 1);
                    check("done_cyc", cyc, mon_e.cyc);
                    check("done_letter", current_letter, mon_e.val);
                end
            end
        end
        prev_ab = {rotary_a, rotary_b};
    end

    // Drive a request in the current cycle and push the expected AB edges and done.
    task automatic accept_now(input logic [4:0] letter, input int limit, output int t_done);
        int l, tgt, fd, bd, n, t0;
        bit up;
        l   = (letter > 26) ? 26 : int'(letter);
        tgt = 4 * l;
        fd  = (tgt - m_pos + 105) % 105;
        bd  = 105 - fd;
        up  = (fd <= bd);
        n   = (fd == 0) ? 0 : (up ? fd : bd);
        if (limit >= 0 && n > limit) n = limit;
        target_valid  = 1'b1;
        target_letter = letter;
        t0 = cyc;
        for (int k = 0; k < n; k++) begin
            if (up) begin
                m_pos = (m_pos == 104) ? 0 : m_pos + 1;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_pos = (m_pos == 0) ? 104 : m_pos - 1;
                m_idx = (m_idx + 3) % 4;
            end
            sb.push_back('{kind: 0, cyc: t0 + 2 + k * P, val: int'(gray_seq[m_idx])});
        end
        t_done = (n == 0) ? t0 + 2 : t0 + 3 + n * P;
        sb.push_back('{kind: 1, cyc: t_done, val: m_pos / 4});
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 2000 && !target_ready; i++) @(negedge clock);
        if (!target_ready) check("ready_timeout", target_ready, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 5000 && !done; i++) @(negedge clock);
        if (!done) check("done_timeout", done, 1);
    endtask

    task automatic run_move(input logic [4:0] letter);
        int td;
        wait_ready();
        accept_now(letter, -1, td);
        @(negedge clock);
        target_valid = 1'b0;
        wait_done();
        check("move_done_cyc", cyc, td);
        @(negedge clock);
    endtask

    task automatic do_reset(input logic [4:0] rv);
        mon_en = 1'b0;
        sb.delete();
        target_valid = 1'b0;
        reset_val = rv;
        reset = 1'b1;
        @(negedge clock);
        check("rst_ab", {rotary_a, rotary_b}, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", target_ready, 1);
        check("rst_done", done, 0);
        check("rst_letter", current_letter, rv);
        reset = 1'b0;
        m_pos = 4 * int'(rv);
        m_idx = 0;
        dec_pos = 4 * int'(rv);
        @(negedge clock);
        @(negedge clock);
        mon_en = 1'b1;
    endtask

    initial begin
        int td1, td2, t0;
        bit got7;
        repeat (3) @(negedge clock);

        // up path: 0 -> 1
        do_reset(5'd0);
        run_move(5'd1);
        check("up_letter", current_letter, 1);

        // down path across the wrap: 0 -> 26 in one step
        do_reset(5'd0);
        run_move(5'd26);
        check("down_letter", current_letter, 26);

        // no move
        do_reset(5'd5);
        run_move(5'd5);

        // request held during a move is ignored until done
        wait_ready();
        accept_now(5'd3, -1, td1);
        @(negedge clock);
        target_letter = 5'd7;
        got7 = 1'b0;
        for (int i = 0; i < 500 && !got7; i++) begin
            @(negedge clock);
            if (target_ready) begin
                check("held_accept_cyc", cyc, td1 + 1);
                accept_now(5'd7, -1, td2);
                got7 = 1'b1;
            end
        end
        if (!got7) check("held_timeout", target_ready, 1);
        @(negedge clock);
        target_valid = 1'b0;
        wait_done();
        check("held_done_cyc", cyc, td2);
        @(negedge clock);

        // reset in the middle of a move
        wait_ready();
        accept_now(5'd20, -1, td1);
        @(negedge clock);
        target_valid = 1'b0;
        repeat (10) @(negedge clock);
        check("mid_busy", busy, 1);
        do_reset(5'd9);

        // loopback through the decoder model, including wraps and saturation
        do_reset(5'd0);
        run_move(5'd13);
        check("lb13_letter", current_letter, dec_pos / 4);
        run_move(5'd25);
        check("lb25_letter", current_letter, dec_pos / 4);
        run_move(5'd2);
        check("lb2_letter", current_letter, dec_pos / 4);
        check("lb2_pos", dec_pos, 8);
        run_move(5'd31);
        check("lbsat_letter", current_letter, dec_pos / 4);
        check("lbsat_pos", dec_pos, 104);

`ifdef ROTARY_QUAD_ABORT_EN
        do_reset(5'd0);
        wait_ready();
        t0 = cyc;
        accept_now(5'd13, 2, td1);
        @(negedge clock);
        target_valid = 1'b0;
        while (cyc < t0 + P + 3) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        wait_done();
        check("abort_done_cyc", cyc, td1);
        repeat (10) @(negedge clock);
        check("abort_dec_pos", dec_pos, 2);
        check("abort_letter", current_letter, 0);
`endif

        repeat (5) @(negedge clock);
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule

// File: doc/rotary_quad_driver.md
Name: rotary_quad_driver

Overview:
- Generates rotary_a/rotary_b quadrature waveforms that move a rotary letter decoder from its current letter to a commanded target letter.
- Serves as the transmit end of the rotary interface: bench stimulus, demo auto-play, and board self-test in loopback.
- Tracks the same 0..104 position count as the decoder (4 quarter-steps per letter, letters 0..26) and always takes the shorter path around the wrap.

Parameters:
- PHASE_CYCLES, 16, clock cycles each AB state is held; must be >= 4 to clear the 2-flop synchronizer and quadrature FSM at the receiver.
- COUNT_MAX, 104, highest position count; positions wrap over COUNT_MAX+1 = 105 values.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- reset_val  input  5  start letter, loaded at reset
- target_valid  input  1  target request
- target_letter  input  5  requested letter, 0..26
- target_ready  output  1  high in IDLE only
- rotary_a  output  1  quadrature A
- rotary_b  output  1  quadrature B
- busy  output  1  high from acceptance until done
- done  output  1  one-cycle pulse when the move completes
- current_letter  output  5  pos >> 2, registered

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Reset values:
  - pos = {reset_val, 2'b00}
  - AB = 00
  - target_ready = 1, busy = 0, done = 0
  - current_letter = reset_val
  - state = IDLE
- Handshake: a request is accepted on the cycle where target_valid && target_ready. target_valid while busy is ignored and not queued.
- target_letter > 26 saturates to 26.
- States:
  - IDLE: on accept, latch tgt = {letter, 2'b00}, go to CALC.
  - CALC, 1 cycle:
    - fd = (tgt - pos) mod 105; bd = 105 - fd.
    - fd == 0: go to DONE.
    - fd <= bd: dir = up, steps = fd. Otherwise dir = down, steps = bd. A tie is impossible because 105 is odd.
    - Otherwise go to STEP.
  - STEP:
    - On entry, advance phase one Gray step and update pos (up: 104 -> 0 wrap, else +1; down: 0 -> 104 wrap, else -1); steps decrements.
    - Hold AB for PHASE_CYCLES cycles.
    - Then re-enter STEP if steps != 0, else go to DONE.
  - DONE: done = 1 for one cycle, busy drops, return to IDLE. Ready is high the following cycle.
- Gray sequence: a 2-bit phase register kept separately from pos, since 105 is not a multiple of 4.
  - Up (A leads): AB 00 -> 10 -> 11 -> 01 -> 00.
  - Down (B leads): AB 00 -> 01 -> 11 -> 10 -> 00.
  - Exactly one of A/B changes per step.
- Latency: accept at cycle T, CALC at T+1, first AB edge visible at T+2. Total move time is steps*PHASE_CYCLES + 3 cycles to the done pulse.
- current_letter is updated the cycle after pos changes.
- Reset mid-move: everything returns to reset values on the next edge, and AB snaps to 00. A receiver may see one spurious transition; this is accepted.
- Hold counter width: $clog2(PHASE_CYCLES). Steps counter: 7 bits (max 52).

Optional Feature:
- Macro: ROTARY_QUAD_ABORT_EN.
- With the macro defined:
  - An extra input, abort (1 bit), is present.
  - abort sampled high in STEP sets steps to 0.
  - The current phase hold completes normally, then the block goes to DONE. AB and pos remain at the last emitted step; there is no rollback.
  - abort in IDLE, CALC or DONE has no effect.
- Without the macro: no abort port, and every move runs to completion.

Decomposition:
- Package rotary_pkg:
  - COUNT_MAX = 104, POS_COUNT = 105, LETTER_MAX = 26.
  - Gray up/down next-phase constants.
  - State enum {IDLE, CALC, STEP, DONE}.
- Sub-module quad_phase_gen:
  - Holds the 2-bit phase register and its AB mapping.
  - Inputs: step strobe, dir, reset.
  - Outputs: rotary_a, rotary_b.

Test Plan (PHASE_CYCLES=4):
- reset_val=0, target 1 -> up path.
  - AB sequence 10, 11, 01, 00, each held 4 cycles; first edge at accept+2.
  - done 19 cycles after accept; current_letter = 1.
- reset_val=0, target 26 -> down path.
  - fd = 104, bd = 1, so one step: AB = 01, pos = 104.
  - current_letter = 26; done at accept+7.
- Target equal to current letter (5 -> 5) -> no AB toggle, done at accept+2.
- target_valid held during a move to 3, with a second target 7 presented:
  - target_ready stays low and 7 is ignored until done.
  - 7 is accepted on the cycle after done.
- Reset asserted mid-STEP:
  - Next cycle: AB = 00, busy = 0, ready = 1, current_letter = reset_val.
- Loopback into the rotary letter decoder with enable = 1 and matching reset_val; targets 0 -> 13 -> 25 -> 2:
  - Decoder letter equals current_letter after each done.
  - With ROTARY_QUAD_ABORT_EN, abort after the 2nd step of 0 -> 13 leaves pos = 2 on both sides.
